pipe_ex: RTL and testbench
==========================

# pipe_ex

- Execute stage of the in-order pipeline: sits between decode and `pipe_wb`.
- Takes one decoded uop per handshake and computes ALU results in a single cycle.
- Runs LOAD/STORE uops through a req/gnt/rvalid data-memory port using a small FSM.
- Presents the result to writeback as `exToWb_t` through a registered valid/ready output slot.

## Interface
Parameters:
- `XLEN`, default 32: datapath width.

Ports (clock and reset first):
- `clk_i`  in  1  sole clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `idToEx_i`  in  idToEx_t  decoded uop. Fields used: `uop_info` (`fu_op`, `alu_op`, `mem_size`, `rd`, `rd_wen`), `rs1_data`, `rs2_data`, `imm`, `use_imm`.
- `id_valid_i`  in  1  uop valid.
- `ex_ready_o`  out  1  stage can accept a uop this cycle.
- `exToWb_o`  out  exToWb_t  `{uop_info, alu_res, lsu_res}`, registered.
- `ex_valid_o`  out  1  `exToWb_o` valid.
- `wb_ready_i`  in  1  writeback accepts this cycle.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = store.
- `mem_addr_o`  out  XLEN  word-aligned address (`[1:0]`=0).
- `mem_wdata_o`  out  XLEN  lane-shifted store data.
- `mem_wstrb_o`  out  4  byte enables.
- `mem_gnt_i`  in  1  request accepted.
- `mem_rvalid_i`  in  1  load data valid.
- `mem_rdata_i`  in  XLEN  load data (full word).

## Operation
- Operand B = `use_imm ? imm : rs2_data`.
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shamt = B[4:0]), SLT (signed), SLTU, PASSB. Results wrap mod 2^XLEN.
- Effective address `ea = rs1_data + imm`.
- Accept when `id_valid_i && ex_ready_o`.
- `ex_ready_o = (state==IDLE) && (!ex_valid_o || wb_ready_i)`.
- Non-memory uop: at the accept edge, `alu_res` and `uop_info` load into the output slot, `lsu_res`=0, `ex_valid_o`=1.
- Memory uop: at the accept edge, the block latches `uop_info`, `ea`, wdata and wstrb; FSM IDLE→MEM_REQ.
- FSM states:
  - IDLE: no memory transaction.
  - MEM_REQ: `mem_req_o`=1, address/data/strobe held stable until `mem_gnt_i`.
    - On gnt, store: output slot loaded (`alu_res`=ea, `lsu_res`=0), →IDLE.
    - On gnt, load: →MEM_WAIT.
  - MEM_WAIT: `mem_req_o`=0. On `mem_rvalid_i`: output slot loaded (`alu_res`=ea, `lsu_res`=formatted data), →IDLE.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001<<ea[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011<<{ea[1],0}.
  - SW: wdata = rs2, wstrb = 1111.
- Load formatting:
  - Select byte/half of `mem_rdata_i` by ea[1:0] / ea[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW takes the full word.
- Misaligned halfword/word: ea[0] (and ea[1] for words) is ignored; no exception is raised.
- Output slot: cleared (`ex_valid_o`→0) on `ex_valid_o && wb_ready_i` unless reloaded on the same edge. Contents hold while `ex_valid_o && !wb_ready_i`.
- Output-slot loading: during MEM_REQ/MEM_WAIT the slot is empty, because accept required it empty or draining. Memory completion therefore always loads the slot with no conflict.
- `uop_info` passes through unchanged; stores carry `rd_wen` from decode (decode drives 0).

## Timing
- Reset (`rst_i`=0 at a rising edge) forces:
  - `state`=IDLE, `ex_valid_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_wstrb_o`=0.
  - `exToWb_o` data is don't-care.
  - `ex_ready_o` is 1 in the first cycle after reset deasserts.
- ALU uop accepted at edge N: `ex_valid_o`=1 in cycle N+1.
- Memory uop accepted at edge N: `mem_req_o`=1 from cycle N+1.
  - With gnt in N+1 and rvalid in N+2, load `ex_valid_o`=1 in cycle N+3.
  - Store with gnt in N+1: `ex_valid_o`=1 in cycle N+2.
- `mem_rvalid_i` in the same cycle as gnt is not supported; rvalid is only sampled in MEM_WAIT.
- Back-to-back ALU uops with `wb_ready_i`=1: one per cycle, full throughput.
- Simultaneous drain and accept (`ex_valid_o && wb_ready_i && id_valid_i`, ALU uop): the slot is reloaded and `ex_valid_o` stays 1.
- Reset mid-transaction: the in-flight request is abandoned and `mem_req_o` drops the next cycle. A later stray `mem_rvalid_i` in IDLE is ignored.
- `mem_gnt_i`/`mem_rvalid_i` outside MEM_REQ/MEM_WAIT are ignored.

## Test plan
- **Reset:** hold `rst_i`=0 for 2 cycles with `id_valid_i`=1 → `ex_valid_o`=0, `mem_req_o`=0. After release, `ex_ready_o`=1.
- **ALU stream:** ADD 5+7, SUB 3−5, SRA 0x80000000>>4, SLTU 1<0xFFFFFFFF on consecutive cycles with `wb_ready_i`=1 → `alu_res` 12, 0xFFFFFFFE, 0xF8000000, 1 in cycles N+1..N+4.
- **Backpressure:** `wb_ready_i`=0 for 3 cycles while ADD is in the slot → `ex_ready_o`=0, `exToWb_o` stable. Raise ready → next uop accepted the same edge the slot drains.
- **Loads:** mem word 0x8081_F0F1.
  - LB at ea=0x1002 → `lsu_res`=0xFFFFFF81.
  - LHU at ea=0x1002 → `lsu_res`=0x00008081.
  - Checks: `mem_addr_o`=0x1000; with gnt delayed 2 cycles, `mem_req_o` is held 3 cycles with a stable address.
- **Stores:**
  - SB rs2=0x12345678 at ea=0x2003 → `mem_wdata_o`=0x78787878, `mem_wstrb_o`=1000, `ex_valid_o` one cycle after gnt.
  - SH at ea=0x2002 → `mem_wstrb_o`=1100.
- **Reset mid-load:** assert reset in MEM_WAIT, then pulse `mem_rvalid_i` after release → no `ex_valid_o`, state IDLE, next ALU uop executes normally.

Source files
------------

// File: rtl/pipe_ex.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | pipe_ex_pkg / pipe_ex                                                |
// | Execute stage: single-cycle ALU, LOAD/STORE through a req/gnt/rvalid |
// | data-memory port, registered valid/ready result slot to writeback.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+

package pipe_ex_pkg;

   typedef enum logic [1:0] {
      FU_ALU   = 2'd0,
      FU_LOAD  = 2'd1,
      FU_STORE = 2'd2
   } fu_op_e;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   // bit 2 = zero-extend, bits [1:0] = access size (byte/half/word)
   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_size_e;

   typedef struct packed {
      fu_op_e    fu_op;
      alu_op_e   alu_op;
      mem_size_e mem_size;
      logic [4:0] rd;
      logic      rd_wen;
   } uop_info_t;

   localparam int UOP_W = $bits(uop_info_t);

endpackage

// Port vectors are packed structs, MSB first:
//   idToEx_i = {uop_info, rs1_data, rs2_data, imm, use_imm}
//   exToWb_o = {uop_info, alu_res, lsu_res}
module pipe_ex
   import pipe_ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [UOP_W+3*XLEN:0]      idToEx_i,
   input  logic                       id_valid_i,
   output logic                       ex_ready_o,
   output logic [UOP_W+2*XLEN-1:0]    exToWb_o,
   output logic                       ex_valid_o,
   input  logic                       wb_ready_i,
   output logic                       mem_req_o,
   output logic                       mem_we_o,
   output logic [XLEN-1:0]            mem_addr_o,
   output logic [XLEN-1:0]            mem_wdata_o,
   output logic [3:0]                 mem_wstrb_o,
   input  logic                       mem_gnt_i,
   input  logic                       mem_rvalid_i,
   input  logic [XLEN-1:0]            mem_rdata_i
);

   typedef struct packed {
      uop_info_t       uop_info;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic            use_imm;
   } idToEx_t;

   typedef struct packed {
      uop_info_t       uop_info;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] lsu_res;
   } exToWb_t;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_REQ  = 2'd1,
      S_MEM_WAIT = 2'd2
   } state_e;

   idToEx_t         id;
   state_e          state_q;
   exToWb_t         out_q;
   logic            ex_valid_q;
   logic            mem_req_q;
   logic            mem_we_q;
   logic [XLEN-1:0] ea_q;
   logic [XLEN-1:0] wdata_q;
   logic [3:0]      wstrb_q;
   uop_info_t       mem_uop_q;

   logic [XLEN-1:0] opb;
   logic [4:0]      shamt;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] ea;
   logic [XLEN-1:0] st_wdata;
   logic [3:0]      st_wstrb;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_res;
   logic            accept;
   logic            is_load;
   logic            is_store;

   assign id       = idToEx_i;
   assign opb      = id.use_imm ? id.imm : id.rs2_data;
   assign shamt    = opb[4:0];
   assign ea       = id.rs1_data + id.imm;
   assign is_load  = (id.uop_info.fu_op == FU_LOAD);
   assign is_store = (id.uop_info.fu_op == FU_STORE);

   // A new uop may enter only with no memory transaction in flight and
   // the result slot empty or draining this cycle.
   assign ex_ready_o = (state_q == S_IDLE) && (!ex_valid_q || wb_ready_i);
   assign accept     = id_valid_i && ex_ready_o;

   assign exToWb_o    = out_q;
   assign ex_valid_o  = ex_valid_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = {ea_q[XLEN-1:2], 2'b00};
   assign mem_wdata_o = wdata_q;
   assign mem_wstrb_o = wstrb_q;

   // Single-cycle ALU on rs1 and the selected operand B
   always_comb begin
      alu_res = '0;
      unique case (id.uop_info.alu_op)
         ALU_ADD:   alu_res = id.rs1_data + opb;
         ALU_SUB:   alu_res = id.rs1_data - opb;
         ALU_AND:   alu_res = id.rs1_data & opb;
         ALU_OR:    alu_res = id.rs1_data | opb;
         ALU_XOR:   alu_res = id.rs1_data ^ opb;
         ALU_SLL:   alu_res = id.rs1_data << shamt;
         ALU_SRL:   alu_res = id.rs1_data >> shamt;
         ALU_SRA:   alu_res = $unsigned($signed(id.rs1_data) >>> shamt);
         ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(id.rs1_data) < $signed(opb))};
         ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (id.rs1_data < opb)};
         ALU_PASSB: alu_res = opb;
         default:   alu_res = '0;
      endcase
   end

   // Store data replicated across all lanes; strobes pick the lane(s) from ea
   always_comb begin
      st_wdata = id.rs2_data;
      st_wstrb = 4'b1111;
      unique case (id.uop_info.mem_size[1:0])
         2'b00: begin
            st_wdata = {(XLEN/8){id.rs2_data[7:0]}};
            st_wstrb = 4'b0001 << ea[1:0];
         end
         2'b01: begin
            st_wdata = {(XLEN/16){id.rs2_data[15:0]}};
            st_wstrb = 4'b0011 << {ea[1], 1'b0};
         end
         default: begin
            st_wdata = id.rs2_data;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   // Load data lane select and sign/zero extension from the latched ea
   always_comb begin
      ld_byte = mem_rdata_i[7:0];
      unique case (ea_q[1:0])
         2'b00: ld_byte = mem_rdata_i[7:0];
         2'b01: ld_byte = mem_rdata_i[15:8];
         2'b10: ld_byte = mem_rdata_i[23:16];
         2'b11: ld_byte = mem_rdata_i[31:24];
         default: ld_byte = mem_rdata_i[7:0];
      endcase
      ld_half = ea_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      ld_res  = mem_rdata_i;
      unique case (mem_uop_q.mem_size)
         MEM_B:   ld_res = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         MEM_BU:  ld_res = {{(XLEN-8){1'b0}}, ld_byte};
         MEM_H:   ld_res = {{(XLEN-16){ld_half[15]}}, ld_half};
         MEM_HU:  ld_res = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_res = mem_rdata_i;
      endcase
   end

   // Control FSM, memory port registers and the writeback result slot
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         ex_valid_q <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         wstrb_q    <= 4'b0000;
      end else begin
         // Drain first; any load below on this edge overrides it
         if (ex_valid_q && wb_ready_i) begin
            ex_valid_q <= 1'b0;
         end
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (is_load || is_store) begin
                     mem_uop_q <= id.uop_info;
                     ea_q      <= ea;
                     wdata_q   <= st_wdata;
                     wstrb_q   <= is_store ? st_wstrb : 4'b0000;
                     mem_we_q  <= is_store;
                     mem_req_q <= 1'b1;
                     state_q   <= S_MEM_REQ;
                  end else begin
                     out_q.uop_info <= id.uop_info;
                     out_q.alu_res  <= alu_res;
                     out_q.lsu_res  <= '0;
                     ex_valid_q     <= 1'b1;
                  end
               end
            end
            S_MEM_REQ: begin
               // The slot is known empty here, so completion never conflicts
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  if (mem_we_q) begin
                     out_q.uop_info <= mem_uop_q;
                     out_q.alu_res  <= ea_q;
                     out_q.lsu_res  <= '0;
                     ex_valid_q     <= 1'b1;
                     mem_we_q       <= 1'b0;
                     wstrb_q        <= 4'b0000;
                     state_q        <= S_IDLE;
                  end else begin
                     state_q <= S_MEM_WAIT;
                  end
               end
            end
            S_MEM_WAIT: begin
               if (mem_rvalid_i) begin
                  out_q.uop_info <= mem_uop_q;
                  out_q.alu_res  <= ea_q;
                  out_q.lsu_res  <= ld_res;
                  ex_valid_q     <= 1'b1;
                  state_q        <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ex.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_pipe_ex                                                           |
// | Directed scoreboard bench for the execute stage.                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pipe_ex;
   import pipe_ex_pkg::*;

   localparam int XLEN = 32;
   localparam int ID_W = UOP_W + 3*XLEN + 1;
   localparam int EX_W = UOP_W + 2*XLEN;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [ID_W-1:0] idToEx_i;
   logic            id_valid_i;
   logic            ex_ready_o;
   logic [EX_W-1:0] exToWb_o;
   logic            ex_valid_o;
   logic            wb_ready_i;
   logic            mem_req_o;
   logic            mem_we_o;
   logic [XLEN-1:0] mem_addr_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic [3:0]      mem_wstrb_o;
   logic            mem_gnt_i;
   logic            mem_rvalid_i;
   logic [XLEN-1:0] mem_rdata_i;

   pipe_ex #(.XLEN(XLEN)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .idToEx_i     (idToEx_i),
      .id_valid_i   (id_valid_i),
      .ex_ready_o   (ex_ready_o),
      .exToWb_o     (exToWb_o),
      .ex_valid_o   (ex_valid_o),
      .wb_ready_i   (wb_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_wstrb_o  (mem_wstrb_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;
   int cycle    = 0;
   logic [EX_W-1:0] exp_q[$];

   // memory responder controls (written by stimulus only)
   int          gnt_delay = 0;
   bit          rv_block  = 1'b0;
   int          stray_req = 0;
   logic [31:0] mem_word  = 32'h0;

   always @(posedge clk_i) cycle++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      $display("FAIL %s: got timeout/unexpected expected handshake (cycle %0d)", name, cycle);
   endtask

   function automatic uop_info_t mk_info(input fu_op_e f, input alu_op_e a,
                                         input mem_size_e s, input logic [4:0] rd,
                                         input logic wen);
      uop_info_t u;
      u.fu_op = f; u.alu_op = a; u.mem_size = s; u.rd = rd; u.rd_wen = wen;
      return u;
   endfunction

   function automatic logic [ID_W-1:0] mk_id(input uop_info_t u, input logic [31:0] rs1,
                                             input logic [31:0] rs2, input logic [31:0] imm,
                                             input logic ui);
      return {u, rs1, rs2, imm, ui};
   endfunction

   function automatic logic [EX_W-1:0] mk_ex(input uop_info_t u, input logic [31:0] a,
                                             input logic [31:0] l);
      return {u, a, l};
   endfunction

   task automatic tick;
      @(posedge clk_i); #1;
   endtask

   // Present a uop until accepted; returns at accept edge + 1
   task automatic send(input logic [ID_W-1:0] u, input logic [EX_W-1:0] e,
                       input bit push, output int waited);
      waited = 0;
      idToEx_i   = u;
      id_valid_i = 1'b1;
      #1;
      while (!ex_ready_o && waited < 50) begin
         @(posedge clk_i); #2;
         waited++;
      end
      if (!ex_ready_o) begin
         note_fail("accept_timeout");
         id_valid_i = 1'b0;
      end else begin
         if (push) exp_q.push_back(e);
         @(posedge clk_i); #1;
         id_valid_i = 1'b0;
      end
   endtask

   task automatic drain;
      int w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         tick();
         w++;
      end
      if (exp_q.size() != 0) note_fail("drain_timeout");
   endtask

   // Monitor: pops and compares on every writeback handshake
   initial begin
      logic [EX_W-1:0] e;
      forever begin
         @(negedge clk_i);
         if (rst_i === 1'b1 && ex_valid_o && wb_ready_i) begin
            if (exp_q.size() == 0) note_fail("wb_unexpected");
            else begin
               e = exp_q.pop_front();
               chk("wb_out", exToWb_o, e);
            end
         end
      end
   end

   // Memory responder: drives gnt/rvalid at the falling edge
   initial begin
      int g_cnt = 0;
      bit pend_rv = 1'b0;
      int stray_done = 0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
         if (rst_i !== 1'b1) begin
            pend_rv = 1'b0; g_cnt = 0;
         end else if (stray_req != stray_done) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; stray_done = stray_req;
         end else if (pend_rv) begin
            if (!rv_block) begin
               mem_rvalid_i = 1'b1; mem_rdata_i = mem_word; pend_rv = 1'b0;
            end
         end else if (mem_req_o) begin
            if (g_cnt >= gnt_delay) begin
               mem_gnt_i = 1'b1; g_cnt = 0; pend_rv = !mem_we_o;
            end else g_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   // Directed stimulus
   initial begin
      uop_info_t ia, il, ist;
      int w, c0;
      rst_i      = 1'b0;
      wb_ready_i = 1'b1;
      id_valid_i = 1'b1;
      idToEx_i   = mk_id(mk_info(FU_ALU, ALU_ADD, MEM_W, 5'd1, 1'b1), 1, 2, 0, 1'b0);

      // reset held two cycles with a valid uop present
      tick(); tick();
      chk("rst_ex_valid", ex_valid_o, 0);
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_wstrb", mem_wstrb_o, 0);
      rst_i = 1'b1; id_valid_i = 1'b0;
      #1;
      chk("rst_ready", ex_ready_o, 1);

      // ALU stream, one per cycle
      ia = mk_info(FU_ALU, ALU_ADD, MEM_W, 5'd3, 1'b1);
      c0 = cycle;
      send(mk_id(ia, 5, 7, 0, 1'b0), mk_ex(ia, 12, 0), 1'b1, w);
      chk("alu_valid_n1", ex_valid_o, 1);
      ia.alu_op = ALU_SUB;
      send(mk_id(ia, 3, 5, 0, 1'b0), mk_ex(ia, 32'hFFFFFFFE, 0), 1'b1, w);
      ia.alu_op = ALU_SRA;
      send(mk_id(ia, 32'h80000000, 32'h55, 4, 1'b1), mk_ex(ia, 32'hF8000000, 0), 1'b1, w);
      ia.alu_op = ALU_SLTU;
      send(mk_id(ia, 1, 32'hFFFFFFFF, 0, 1'b0), mk_ex(ia, 1, 0), 1'b1, w);
      chk("alu_throughput", cycle - c0, 4);
      drain();

      // Backpressure
      wb_ready_i = 1'b0;
      ia.alu_op = ALU_ADD;
      send(mk_id(ia, 32'h10, 32'h20, 0, 1'b0), mk_ex(ia, 32'h30, 0), 1'b1, w);
      for (int i = 0; i < 3; i++) begin
         chk("bp_not_ready", ex_ready_o, 0);
         chk("bp_hold", exToWb_o, mk_ex(ia, 32'h30, 0));
         tick();
      end
      wb_ready_i = 1'b1;
      ia.alu_op = ALU_XOR;
      send(mk_id(ia, 32'hF0F0, 32'h0FF0, 0, 1'b0), mk_ex(ia, 32'hFF00, 0), 1'b1, w);
      chk("bp_same_edge", w, 0);
      chk("bp_reload_valid", ex_valid_o, 1);
      drain();

      // Loads
      mem_word  = 32'h8081F0F1;
      gnt_delay = 2;
      il = mk_info(FU_LOAD, ALU_ADD, MEM_B, 5'd7, 1'b1);
      send(mk_id(il, 32'h1000, 0, 2, 1'b1), mk_ex(il, 32'h1002, 32'hFFFFFF81), 1'b1, w);
      for (int i = 0; i < 3; i++) begin
         chk("ld_req_held", mem_req_o, 1);
         chk("ld_addr", mem_addr_o, 32'h1000);
         tick();
      end
      chk("ld_req_dropped", mem_req_o, 0);
      drain();

      gnt_delay = 0;
      il.mem_size = MEM_HU;
      send(mk_id(il, 32'h1000, 0, 2, 1'b1), mk_ex(il, 32'h1002, 32'h00008081), 1'b1, w);
      chk("lhu_req", mem_req_o, 1);
      chk("lhu_we", mem_we_o, 0);
      tick();
      chk("lhu_wait_valid", ex_valid_o, 0);
      tick();
      chk("lhu_valid_n3", ex_valid_o, 1);
      drain();

      // Stores
      ist = mk_info(FU_STORE, ALU_ADD, MEM_B, 5'd0, 1'b0);
      send(mk_id(ist, 32'h2000, 32'h12345678, 3, 1'b1), mk_ex(ist, 32'h2003, 0), 1'b1, w);
      chk("sb_we", mem_we_o, 1);
      chk("sb_addr", mem_addr_o, 32'h2000);
      chk("sb_wdata", mem_wdata_o, 32'h78787878);
      chk("sb_wstrb", mem_wstrb_o, 4'b1000);
      chk("sb_valid_early", ex_valid_o, 0);
      tick();
      chk("sb_valid_after_gnt", ex_valid_o, 1);
      drain();

      ist.mem_size = MEM_H;
      send(mk_id(ist, 32'h2000, 32'h12345678, 2, 1'b1), mk_ex(ist, 32'h2002, 0), 1'b1, w);
      chk("sh_wdata", mem_wdata_o, 32'h56785678);
      chk("sh_wstrb", mem_wstrb_o, 4'b1100);
      drain();

      // Reset during MEM_WAIT, then a stray rvalid
      rv_block = 1'b1;
      il.mem_size = MEM_W;
      send(mk_id(il, 32'h3000, 0, 0, 1'b1), mk_ex(il, 32'h3000, 0), 1'b0, w);
      tick();
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      chk("rml_req", mem_req_o, 0);
      chk("rml_valid", ex_valid_o, 0);
      stray_req++;
      rv_block = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rml_stray_ignored", ex_valid_o, 0);
         chk("rml_ready", ex_ready_o, 1);
      end
      ia.alu_op = ALU_ADD;
      send(mk_id(ia, 100, 23, 0, 1'b0), mk_ex(ia, 123, 0), 1'b1, w);
      drain();

      tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
